// File: rtl/match_sequencer.sv
// Pong game-flow controller.
// Debounces the pause/start and restart buttons, sequences the match through
// idle, serve, rally, pause and win phases, gates datapath motion and owns
// the scores and winner/goal flags used by the display and LED blocks.

// Per-key front end: 2-flop synchroniser, debounce counter, press detector.
// After reset a key must first be seen released for a full debounce window
// before its next press is honoured, so a key held through reset is not a press.
module match_sequencer_key #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic CLOCK_25,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          armed_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          ref_lvl;

    // Until armed, the counter measures a stable released (high) level.
    assign ref_lvl = armed_q ? level_q : 1'b0;

    // Bring the asynchronous key into the clock domain.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= key_n_i;
            sync_q <= meta_q;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync_q == ref_lvl) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                if (armed_q) begin
                    level_q <= sync_q;
                    press_q <= ~sync_q;
                end else begin
                    armed_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// state  | meaning
// IDLE   | no match running, waiting for start press
// SERVE  | ball recentred, counting ticks before the rally
// PLAY   | rally in progress, datapath may move
// PAUSED | frozen, resumes to SERVE or PLAY on the next start press
// WIN    | win screen held for a fixed number of ticks
module match_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int WIN_SCORE         = 8,
    parameter int SERVE_DELAY_TICKS = 60,
    parameter int WIN_HOLD_TICKS    = 180
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic       key0,
    input  logic       key1,
    input  logic       tick,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic       run_en,
    output logic       serve_req,
    output logic       serve_dir,
    output logic       game_reset,
    output logic [2:0] score_1,
    output logic [2:0] score_2,
    output logic       win_1,
    output logic       win_2,
    output logic       goal_1,
    output logic       goal_2
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_PAUSED,
        ST_WIN
    } state_t;

    localparam int TMAX = (SERVE_DELAY_TICKS > WIN_HOLD_TICKS) ? SERVE_DELAY_TICKS : WIN_HOLD_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_DELAY_TICKS - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(WIN_HOLD_TICKS - 1);
    // A goal scored from this value wins instead of incrementing.
    localparam logic [2:0]    LAST_GOAL  = 3'(WIN_SCORE - 1);

    logic p0;
    logic p1;

    state_t        state_q, state_d;
    logic          ret_play_q, ret_play_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          run_en_q, run_en_d;
    logic          serve_req_q, serve_req_d;
    logic          serve_dir_q, serve_dir_d;
    logic          game_reset_q, game_reset_d;
    logic [2:0]    score_1_q, score_1_d;
    logic [2:0]    score_2_q, score_2_d;
    logic          win_1_q, win_1_d;
    logic          win_2_q, win_2_d;
    logic          goal_1_q, goal_1_d;
    logic          goal_2_q, goal_2_d;

    match_sequencer_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .key_n_i  (key0),
        .press_o  (p0)
    );

    match_sequencer_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .key_n_i  (key1),
        .press_o  (p1)
    );

    // Next-state and next-output decode; restart beats goals, goals beat pause.
    always_comb begin
        state_d      = state_q;
        ret_play_d   = ret_play_q;
        tick_d       = tick_q;
        serve_req_d  = 1'b0;
        serve_dir_d  = serve_dir_q;
        game_reset_d = 1'b0;
        score_1_d    = score_1_q;
        score_2_d    = score_2_q;
        win_1_d      = win_1_q;
        win_2_d      = win_2_q;
        goal_1_d     = goal_1_q;
        goal_2_d     = goal_2_q;

        if (p1) begin
            game_reset_d = 1'b1;
            score_1_d    = '0;
            score_2_d    = '0;
            goal_1_d     = 1'b0;
            goal_2_d     = 1'b0;
            win_1_d      = 1'b0;
            win_2_d      = 1'b0;
            serve_dir_d  = 1'b0;
            tick_d       = '0;
            state_d      = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (p0) begin
                        state_d     = ST_SERVE;
                        serve_req_d = 1'b1;
                        tick_d      = '0;
                    end
                end
                ST_SERVE: begin
                    if (p0) begin
                        // Tick count is kept so the serve resumes where it left off.
                        state_d    = ST_PAUSED;
                        ret_play_d = 1'b0;
                    end else if (tick) begin
                        if (tick_q == SERVE_LAST) begin
                            state_d  = ST_PLAY;
                            goal_1_d = 1'b0;
                            goal_2_d = 1'b0;
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (goal_p1) begin
                        if (score_1_q == LAST_GOAL) begin
                            state_d = ST_WIN;
                            win_1_d = 1'b1;
                            tick_d  = '0;
                        end else begin
                            score_1_d   = score_1_q + 1'b1;
                            goal_1_d    = 1'b1;
                            serve_dir_d = 1'b0;
                            state_d     = ST_SERVE;
                            serve_req_d = 1'b1;
                            tick_d      = '0;
                        end
                    end else if (goal_p2) begin
                        if (score_2_q == LAST_GOAL) begin
                            state_d = ST_WIN;
                            win_2_d = 1'b1;
                            tick_d  = '0;
                        end else begin
                            score_2_d   = score_2_q + 1'b1;
                            goal_2_d    = 1'b1;
                            serve_dir_d = 1'b1;
                            state_d     = ST_SERVE;
                            serve_req_d = 1'b1;
                            tick_d      = '0;
                        end
                    end else if (p0) begin
                        state_d    = ST_PAUSED;
                        ret_play_d = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (p0) begin
                        state_d = ret_play_q ? ST_PLAY : ST_SERVE;
                    end
                end
                ST_WIN: begin
                    if (tick) begin
                        if (tick_q == HOLD_LAST) begin
                            score_1_d    = '0;
                            score_2_d    = '0;
                            win_1_d      = 1'b0;
                            win_2_d      = 1'b0;
                            game_reset_d = 1'b1;
                            tick_d       = '0;
                            state_d      = ST_IDLE;
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        run_en_d = (state_d == ST_PLAY);
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ret_play_q   <= 1'b0;
            tick_q       <= '0;
            run_en_q     <= 1'b0;
            serve_req_q  <= 1'b0;
            serve_dir_q  <= 1'b0;
            game_reset_q <= 1'b0;
            score_1_q    <= '0;
            score_2_q    <= '0;
            win_1_q      <= 1'b0;
            win_2_q      <= 1'b0;
            goal_1_q     <= 1'b0;
            goal_2_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_play_q   <= ret_play_d;
            tick_q       <= tick_d;
            run_en_q     <= run_en_d;
            serve_req_q  <= serve_req_d;
            serve_dir_q  <= serve_dir_d;
            game_reset_q <= game_reset_d;
            score_1_q    <= score_1_d;
            score_2_q    <= score_2_d;
            win_1_q      <= win_1_d;
            win_2_q      <= win_2_d;
            goal_1_q     <= goal_1_d;
            goal_2_q     <= goal_2_d;
        end
    end

    assign run_en     = run_en_q;
    assign serve_req  = serve_req_q;
    assign serve_dir  = serve_dir_q;
    assign game_reset = game_reset_q;
    assign score_1    = score_1_q;
    assign score_2    = score_2_q;
    assign win_1      = win_1_q;
    assign win_2      = win_2_q;
    assign goal_1     = goal_1_q;
    assign goal_2     = goal_2_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Testbench for match_sequencer: directed scenarios plus randomized play,
// every cycle compared against a behavioural model of the game rules.
module tb_match_sequencer;

    localparam int D  = 4;
    localparam int SD = 3;
    localparam int WH = 5;
    localparam int WS = 8;

    localparam int P_IDLE   = 0;
    localparam int P_SERVE  = 1;
    localparam int P_PLAY   = 2;
    localparam int P_PAUSED = 3;
    localparam int P_WIN    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       key0;
    logic       key1;
    logic       tick;
    logic       goal_p1;
    logic       goal_p2;
    logic       run_en;
    logic       serve_req;
    logic       serve_dir;
    logic       game_reset;
    logic [2:0] score_1;
    logic [2:0] score_2;
    logic       win_1;
    logic       win_2;
    logic       goal_1;
    logic       goal_2;

    always #5 clk = ~clk;

    match_sequencer #(
        .DEBOUNCE_CYCLES   (D),
        .WIN_SCORE         (WS),
        .SERVE_DELAY_TICKS (SD),
        .WIN_HOLD_TICKS    (WH)
    ) dut (
        .CLOCK_25   (clk),
        .reset      (reset),
        .key0       (key0),
        .key1       (key1),
        .tick       (tick),
        .goal_p1    (goal_p1),
        .goal_p2    (goal_p2),
        .run_en     (run_en),
        .serve_req  (serve_req),
        .serve_dir  (serve_dir),
        .game_reset (game_reset),
        .score_1    (score_1),
        .score_2    (score_2),
        .win_1      (win_1),
        .win_2      (win_2),
        .goal_1     (goal_1),
        .goal_2     (goal_2)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_sreq  = 0;
    int n_grst  = 0;

    logic rst_lvl;
    logic k0_lvl;
    logic k1_lvl;

    // Game model
    int m_phase, m_ret, m_ticks, m_s1, m_s2;
    bit m_w1, m_w2, m_g1, m_g2, m_dir, m_sreq, m_grst;
    // Key model: raw key values are seen two edges late; a new level is
    // accepted after D consecutive equal samples; pend = press seen by game.
    bit hist_a[2], hist_b[2], prev_s[2], lvl[2], armed[2], pend[2];
    int run[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] dut_vec();
        return {18'd0, run_en, serve_req, serve_dir, game_reset, score_1, score_2,
                win_1, win_2, goal_1, goal_2};
    endfunction

    function automatic logic [31:0] model_vec();
        logic run_m;
        run_m = (m_phase == P_PLAY);
        return {18'd0, run_m, m_sreq, m_dir, m_grst, 3'(m_s1), 3'(m_s2),
                m_w1, m_w2, m_g1, m_g2};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_ret = P_IDLE; m_ticks = 0; m_s1 = 0; m_s2 = 0;
        m_w1 = 0; m_w2 = 0; m_g1 = 0; m_g2 = 0; m_dir = 0; m_sreq = 0; m_grst = 0;
        for (int k = 0; k < 2; k++) begin
            hist_a[k] = 1; hist_b[k] = 1; prev_s[k] = 1; lvl[k] = 1;
            armed[k] = 0; pend[k] = 0; run[k] = 0;
        end
    endtask

    task automatic key_model(input int k, input bit key_now, output bit fire);
        bit s;
        s = hist_b[k];
        hist_b[k] = hist_a[k];
        hist_a[k] = key_now;
        if (run[k] > 0 && s == prev_s[k]) run[k]++;
        else run[k] = 1;
        prev_s[k] = s;
        fire = 0;
        if (!armed[k]) begin
            if (s && run[k] >= D) armed[k] = 1;
        end else if (s != lvl[k] && run[k] >= D) begin
            lvl[k] = s;
            fire = !s;
        end
    endtask

    task automatic start_serve();
        m_phase = P_SERVE; m_sreq = 1; m_ticks = 0;
    endtask

    task automatic model_fsm(input bit t, input bit g1, input bit g2);
        m_sreq = 0; m_grst = 0;
        if (pend[1]) begin
            m_grst = 1; m_s1 = 0; m_s2 = 0; m_g1 = 0; m_g2 = 0;
            m_w1 = 0; m_w2 = 0; m_dir = 0; m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: if (pend[0]) start_serve();
                P_SERVE: begin
                    if (pend[0]) begin m_ret = P_SERVE; m_phase = P_PAUSED; end
                    else if (t) begin
                        m_ticks++;
                        if (m_ticks == SD) begin m_phase = P_PLAY; m_g1 = 0; m_g2 = 0; end
                    end
                end
                P_PLAY: begin
                    if (g1) begin
                        if (m_s1 + 1 == WS) begin m_w1 = 1; m_phase = P_WIN; m_ticks = 0; end
                        else begin m_s1++; m_g1 = 1; m_dir = 0; start_serve(); end
                    end else if (g2) begin
                        if (m_s2 + 1 == WS) begin m_w2 = 1; m_phase = P_WIN; m_ticks = 0; end
                        else begin m_s2++; m_g2 = 1; m_dir = 1; start_serve(); end
                    end else if (pend[0]) begin
                        m_ret = P_PLAY; m_phase = P_PAUSED;
                    end
                end
                P_PAUSED: if (pend[0]) m_phase = m_ret;
                P_WIN: begin
                    if (t) begin
                        m_ticks++;
                        if (m_ticks == WH) begin
                            m_s1 = 0; m_s2 = 0; m_w1 = 0; m_w2 = 0; m_grst = 1; m_phase = P_IDLE;
                        end
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    // One clock: drive inputs, advance model, compare after the edge.
    task automatic cyc(input bit t, input bit g1, input bit g2);
        bit f0, f1;
        reset = rst_lvl; key0 = k0_lvl; key1 = k1_lvl;
        tick = t; goal_p1 = g1; goal_p2 = g2;
        if (rst_lvl) model_reset();
        else begin
            model_fsm(t, g1, g2);
            key_model(0, k0_lvl, f0);
            key_model(1, k1_lvl, f1);
            pend[0] = f0;
            pend[1] = f1;
        end
        @(negedge clk);
        check("cycle", dut_vec(), model_vec());
        if (serve_req) n_sreq++;
        if (game_reset) n_grst++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0);
    endtask

    // Press acts on the game at the 7th low cycle; then a clean release.
    task automatic press0();
        k0_lvl = 0; idle(8);
        k0_lvl = 1; idle(8);
    endtask

    initial begin
        rst_lvl = 1; k0_lvl = 1; k1_lvl = 1;
        reset = 1; key0 = 1; key1 = 1; tick = 0; goal_p1 = 0; goal_p2 = 0;
        model_reset();
        @(negedge clk);
        check("reset_outs", dut_vec(), 32'd0);
        cyc(0, 0, 0);
        rst_lvl = 0;
        idle(8);

        // Start with bounces before a real press
        n_sreq = 0;
        for (int b = 0; b < 2; b++) begin
            k0_lvl = 0; idle(2);
            k0_lvl = 1; idle(2);
        end
        check("bounce_no_serve", n_sreq, 0);
        k0_lvl = 0; idle(10);
        k0_lvl = 1; idle(10);
        check("start_one_serve", n_sreq, 1);
        check("start_run_low", run_en, 0);
        ticks(2);
        check("serve_2ticks", run_en, 0);
        ticks(1);
        check("serve_3ticks", run_en, 1);

        // Rally goal by player 2
        cyc(0, 0, 1);
        check("g2_score", score_2, 1);
        check("g2_flag", goal_2, 1);
        check("g2_dir", serve_dir, 1);
        check("g2_sreq", serve_req, 1);
        check("g2_run", run_en, 0);
        cyc(0, 0, 0);
        check("g2_sreq_end", serve_req, 0);
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
        check("g2_flag_hold", goal_2, 1);
        cyc(1, 0, 0);
        check("g2_rally_run", run_en, 1);
        check("g2_flag_clr", goal_2, 0);

        // Pause in PLAY
        press0();
        check("pause_run", run_en, 0);
        cyc(0, 1, 0);
        check("pause_ign_g1", score_1, 0);
        cyc(0, 0, 1);
        check("pause_ign_g2", score_2, 1);
        n_sreq = 0;
        press0();
        check("resume_run", run_en, 1);
        check("resume_no_sreq", n_sreq, 0);

        // Pause in SERVE after one tick
        cyc(0, 1, 0);
        check("srv_score1", score_1, 1);
        ticks(1);
        press0();
        ticks(2);
        check("srv_paused", run_en, 0);
        press0();
        ticks(1);
        check("srv_resume_1", run_en, 0);
        ticks(1);
        check("srv_resume_2", run_en, 1);

        // Simultaneous goals: only player 1 counts
        cyc(0, 1, 1);
        check("both_s1", score_1, 2);
        check("both_s2", score_2, 1);
        ticks(3);
        check("both_play", run_en, 1);

        // Restart coincident with a goal
        k1_lvl = 0; idle(6);
        cyc(0, 1, 0);
        check("rst_grst", game_reset, 1);
        check("rst_s1", score_1, 0);
        check("rst_s2", score_2, 0);
        check("rst_run", run_en, 0);
        cyc(0, 0, 0);
        check("rst_grst_end", game_reset, 0);
        k1_lvl = 1; idle(8);

        // Win by player 1
        press0();
        ticks(3);
        for (int g = 0; g < 7; g++) begin
            cyc(0, 1, 0);
            ticks(3);
        end
        check("pre_win_s1", score_1, 7);
        check("pre_win_run", run_en, 1);
        cyc(0, 1, 0);
        check("win_s1", score_1, 7);
        check("win_flag", win_1, 1);
        check("win_run", run_en, 0);
        n_sreq = 0;
        press0();
        check("win_key0_ign", win_1, 1);
        check("win_key0_sreq", n_sreq, 0);
        n_grst = 0;
        ticks(4);
        check("win_hold", win_1, 1);
        check("win_hold_grst", n_grst, 0);
        ticks(1);
        check("win_end_grst", game_reset, 1);
        check("win_end_s1", score_1, 0);
        check("win_end_flag", win_1, 0);
        cyc(0, 0, 0);
        check("win_one_grst", n_grst, 1);

        // Async reset mid-SERVE with key0 held across reset release
        press0();
        ticks(3);
        cyc(0, 0, 1);
        k0_lvl = 0;
        cyc(0, 0, 0);
        #2;
        rst_lvl = 1;
        reset = 1;
        #1;
        check("async_rst", dut_vec(), 32'd0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst_lvl = 0;
        n_sreq = 0;
        idle(20);
        check("held_no_press", n_sreq, 0);
        check("held_run", run_en, 0);
        k0_lvl = 1; idle(8);
        press0();
        check("repress_sreq", n_sreq, 1);

        // Randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) k0_lvl = ~k0_lvl;
            if ($urandom_range(0, 399) == 0) k1_lvl = ~k1_lvl;
            if (rst_lvl) rst_lvl = 0;
            else if ($urandom_range(0, 999) == 0) rst_lvl = 1;
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Central game-flow controller for the Pong datapath. It replaces the multi-edge pause/reset logic and the scattered score and winner registers with one synchronous FSM clocked on CLOCK_25.
- Debounces the two push-buttons and sequences idle, serve, rally, pause and win phases.
- Gates ball/paddle motion via run_en.
- Owns both 3-bit scores and the winner flags that drive the score, win-screen and LED animation blocks.

Parameters:
- DEBOUNCE_CYCLES, 250000, CLOCK_25 cycles a key level must be stable before it is accepted (10 ms).
- WIN_SCORE, 8, goals needed to win; must be in 1..8 to fit the 3-bit score.
- SERVE_DELAY_TICKS, 60, game ticks spent in SERVE before the rally starts.
- WIN_HOLD_TICKS, 180, game ticks the win screen is held before returning to IDLE.

Ports:
- CLOCK_25  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- key0  in  1  pause/start button, active-low, asynchronous to the clock.
- key1  in  1  restart button, active-low, asynchronous to the clock.
- tick  in  1  one-cycle strobe per game step (BALL_CLOCK rising edge, synchronised upstream).
- goal_p1  in  1  one-cycle strobe: player 1 scored (ball passed player 2).
- goal_p2  in  1  one-cycle strobe: player 2 scored.
- run_en  out  1  1 = datapath may move ball and paddles.
- serve_req  out  1  one-cycle pulse: datapath recentres the ball and sets the serve direction.
- serve_dir  out  1  0 = ball serves rightward (toward player 2), 1 = leftward.
- game_reset  out  1  one-cycle pulse: datapath returns paddles and ball to initial positions.
- score_1  out  3  player 1 score.
- score_2  out  3  player 2 score.
- win_1  out  1  high while the WIN state shows player 1 as winner.
- win_2  out  1  high while the WIN state shows player 2 as winner.
- goal_1  out  1  high from a player 1 goal until the next rally starts (LED animation).
- goal_2  out  1  high from a player 2 goal until the next rally starts (LED animation).

Behaviour:
- Reset values: state = IDLE, all outputs 0, counters 0, debounced key levels 1.
- Key input path:
  - Each key passes a 2-flop synchroniser and then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronised value; any bounce restarts the count.
  - A press is a 1->0 transition of the debounced level, giving a one-cycle pulse p0/p1.
  - Releases generate nothing.
- FSM states: IDLE, SERVE, PLAY, PAUSED, WIN.
  - IDLE: run_en = 0. p0 -> SERVE.
  - SERVE:
    - On entry, serve_req pulses for exactly 1 cycle and tick_cnt is cleared.
    - tick_cnt increments on tick; when it reaches SERVE_DELAY_TICKS -> PLAY and goal_1/goal_2 clear.
    - p0 -> PAUSED with ret = SERVE; tick_cnt is frozen, not cleared.
  - PLAY: run_en = 1.
    - goal_p1: if score_1 == WIN_SCORE-1 -> WIN with win_1 = 1; else score_1 += 1, goal_1 = 1, serve_dir = 0, -> SERVE.
    - goal_p2: symmetric; sets goal_2, serve_dir = 1, and on the winning goal sets win_2.
    - p0 -> PAUSED with ret = PLAY.
  - PAUSED: run_en = 0. p0 -> ret.
    - Returning to SERVE does not re-pulse serve_req; only entry from PLAY or IDLE pulses it.
  - WIN:
    - run_en = 0; win_x held; tick_cnt counts ticks.
    - At WIN_HOLD_TICKS: scores clear, win_x clear, game_reset pulses, -> IDLE.
    - p0 is ignored in WIN.
- Goal strobes outside PLAY are ignored.
- Priority within one cycle, highest first: reset > p1 > goal > p0.
  - p1 in any state: game_reset pulses for 1 cycle, scores, goal_x, win_x and serve_dir clear, -> IDLE.
  - goal_p1 and goal_p2 in the same cycle: only goal_p1 is processed.
  - A goal coinciding with p0 in PLAY: the goal is processed and p0 is dropped.
- Score arithmetic: 3-bit unsigned. The winning goal never increments the score, so no wrap occurs.
- run_en is registered; it is high exactly when state == PLAY.
- Asynchronous reset mid-pulse truncates that pulse. After reset release, keys must see a fresh debounced press; a key held low through reset is not a press.

Test Plan (DEBOUNCE_CYCLES=4, SERVE_DELAY_TICKS=3, WIN_HOLD_TICKS=5, WIN_SCORE=8):
- Start: key0 held low 10 cycles, with bounces of 2 cycles before it -> exactly one serve_req pulse; run_en rises after 3 ticks; no pulse on key0 release.
- Rally goal: in PLAY, goal_p2 strobe -> score_2 = 1, goal_2 = 1, serve_dir = 1, serve_req pulse next cycle, run_en = 0 until 3 ticks later; goal_2 clears when run_en rises.
- Win: score_1 = 7 and goal_p1 -> score_1 stays 7, win_1 = 1; after 5 ticks, scores = 0, win_1 = 0, one game_reset pulse, state IDLE; key0 pressed during WIN has no effect.
- Pause: key0 press in PLAY -> run_en = 0 and goal strobes ignored; second press -> run_en = 1 with no serve_req. Pause in SERVE after 1 tick -> resume needs exactly 2 more ticks.
- Priority: goal_p1 and goal_p2 in the same cycle -> only score_1 increments. key1 press coincident with a goal -> scores 0, game_reset pulse, IDLE.
- Async reset: reset asserted between clock edges mid-SERVE -> all outputs 0 immediately. key0 held low across reset release -> no press until released and re-pressed.
